riscv_fetch_prefetch: RTL and testbench

- Instruction-fetch stage for the 5-stage RISC-V pipeline. It sits directly upstream of the decode/register-read stage.
- Issues word-aligned fetch requests to a variable-latency instruction memory and buffers returned words in a DEPTH-entry prefetch FIFO.
- Drives the IF/ID pipeline register (IR, PC, valid) consumed by decode.
- Supports a decode/hazard stall and a PC redirect that flushes the buffered and in-flight fetches.

---
 rtl/riscv_fetch_prefetch.sv | 153 +++++++++++++++
 tb/tb_riscv_fetch_prefetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_prefetch.sv
// Instruction-fetch stage: issues word fetches under a credit limit, buffers returned words
// in a small prefetch FIFO and feeds the IF/ID register; redirects flush and drop stale fetches.
module riscv_fetch_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IR   = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_ir,
    output logic [31:0] ifid_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] CREDITS = DEPTH[CW:0];
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   fifo_ir [DEPTH];
    logic [31:0]   fifo_pc [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_target;
    logic          accept;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [CW-1:0] accept_inc;
    logic [CW-1:0] rsp_dec;
    logic [CW-1:0] push_inc;
    logic [CW-1:0] pop_dec;
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[31:2], 2'b00};

    // Buffered plus in-flight words never exceed DEPTH, so the FIFO cannot overflow.
    assign occupancy      = {1'b0, fifo_count} + {1'b0, inflight};
    assign fifo_empty     = (fifo_count == '0);
    assign imem_req_valid = !reset && !redirect_valid && (occupancy < CREDITS);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are leftovers from before a reset.
    assign rsp_fire = imem_rsp_valid && (inflight != '0);
    assign push     = rsp_fire && (drop == '0) && !redirect_valid;
    assign pop      = !redirect_valid && !stall && !fifo_empty;

    assign accept_inc = {{(CW-1){1'b0}}, accept};
    assign rsp_dec    = {{(CW-1){1'b0}}, rsp_fire};
    assign push_inc   = {{(CW-1){1'b0}}, push};
    assign pop_dec    = {{(CW-1){1'b0}}, pop};

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC_ALIGNED;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
        end else if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // On redirect every fetch still outstanding (minus one returning now) becomes stale.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + accept_inc - rsp_dec;
            if (redirect_valid) begin
                drop <= inflight - rsp_dec;
            end else if (rsp_fire && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_pc <= RESET_PC_ALIGNED;
        end else if (redirect_valid) begin
            rsp_pc <= redirect_target;
        end else if (push) begin
            rsp_pc <= rsp_pc + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_ir[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr] <= rsp_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || redirect_valid) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + push_inc - pop_dec;
        end
    end

    // IF/ID only ever takes words already in the FIFO, giving one edge of latency past capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            ifid_valid <= 1'b0;
            ifid_ir    <= NOP_IR;
            ifid_pc    <= 32'h0000_0000;
        end else if (redirect_valid) begin
            ifid_valid <= 1'b0;
            ifid_ir    <= NOP_IR;
        end else if (stall) begin
            ifid_valid <= ifid_valid;
        end else if (pop) begin
            ifid_valid <= 1'b1;
            ifid_ir    <= fifo_ir[rd_ptr];
            ifid_pc    <= fifo_pc[rd_ptr];
        end else begin
            ifid_valid <= 1'b0;
            ifid_ir    <= NOP_IR;
        end
    end

    assert property (@(posedge clock) disable iff (reset) drop <= inflight);
    assert property (@(posedge clock) disable iff (reset) occupancy <= CREDITS);
    assert property (@(posedge clock) disable iff (reset) imem_req_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_riscv_fetch_prefetch.sv
// Bench for riscv_fetch_prefetch: directed steps plus a random phase, checked each cycle
// against a transaction-level model built from queues of fetches and buffered words.
module tb_riscv_fetch_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_IR   = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pc;

    riscv_fetch_prefetch #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC),
        .NOP_IR  (NOP_IR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ifid_valid    (ifid_valid),
        .ifid_ir       (ifid_ir),
        .ifid_pc       (ifid_pc)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        logic        stale;
    } fetch_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } word_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
        logic        stale;
    } mem_t;

    fetch_t      m_fetches[$];
    word_t       m_words[$];
    mem_t        mem_q[$];
    logic [31:0] m_fetch_pc = RESET_PC;
    logic        m_ifid_valid = 1'b0;
    logic [31:0] m_ifid_ir = NOP_IR;
    logic [31:0] m_ifid_pc = 32'h0;
    logic        m_req;
    bit          model_ready = 1'b0;
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    logic [31:0] last_due = 32'h0;
    int          checks_total = 0;
    int          checks_passed = 0;

    // Memory word for an address: the address with RV32-style low opcode bits, so IR differs from PC.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11};
    endfunction

    function automatic bit mem_has_stale();
        foreach (mem_q[i]) begin
            if (mem_q[i].stale) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit rsp_due();
        return (mem_q.size() > 0) && (mem_q[0].due <= cyc + 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks_total++;
        assert (obs === expv) checks_passed++;
        else $error("[TB] FAIL %s: observed %h expected %h at cycle %0d", tag, obs, expv, cyc);
    endtask

    task automatic check_output();
        m_req = !reset && !redirect_valid && ((m_words.size() + m_fetches.size()) < DEPTH);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, m_req});
        if (m_req && model_ready) chk("req_addr", imem_req_addr, m_fetch_pc);
        if (model_ready) begin
            chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_ifid_valid});
            chk("ifid_ir", ifid_ir, m_ifid_ir);
            chk("ifid_pc", ifid_pc, m_ifid_pc);
        end
    endtask

    // Advances the memory and the reference model across one rising edge.
    task automatic update_models();
        logic        rsp;
        logic [31:0] rdata;
        logic        got;
        logic        deliver;
        fetch_t      f;
        word_t       w;
        logic [31:0] due;
        rsp     = imem_rsp_valid;
        rdata   = imem_rsp_data;
        got     = 1'b0;
        deliver = 1'b0;
        f       = '0;

        if (rsp) void'(mem_q.pop_front());
        if (s_req_valid && imem_req_ready) begin
            due = 32'(cyc + 1 + lat);
            if (due < last_due) due = last_due;
            last_due = due;
            mem_q.push_back('{addr: s_req_addr, due: due, stale: 1'b0});
        end
        if (reset) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        end

        if (reset) begin
            m_fetches.delete();
            m_words.delete();
            m_fetch_pc   = RESET_PC;
            m_ifid_valid = 1'b0;
            m_ifid_ir    = NOP_IR;
            m_ifid_pc    = 32'h0;
            model_ready  = 1'b1;
        end else begin
            if (rsp && m_fetches.size() > 0) begin
                got = 1'b1;
                f   = m_fetches.pop_front();
            end
            deliver = got && !f.stale && !redirect_valid;
            if (redirect_valid) begin
                m_words.delete();
                foreach (m_fetches[i]) m_fetches[i].stale = 1'b1;
                m_fetch_pc   = {redirect_pc[31:2], 2'b00};
                m_ifid_valid = 1'b0;
                m_ifid_ir    = NOP_IR;
            end else if (!stall) begin
                if (m_words.size() > 0) begin
                    w = m_words.pop_front();
                    m_ifid_valid = 1'b1;
                    m_ifid_ir    = w.ir;
                    m_ifid_pc    = w.pc;
                end else begin
                    m_ifid_valid = 1'b0;
                    m_ifid_ir    = NOP_IR;
                end
            end
            if (deliver) m_words.push_back('{pc: f.addr, ir: rdata});
            if (m_req && imem_req_ready) begin
                m_fetches.push_back('{addr: m_fetch_pc, stale: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic stl, input logic rdv,
                                  input logic [31:0] rpc, input logic rdy);
        @(negedge clock);
        reset          = rst;
        stall          = stl;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        imem_req_ready = rdy && !mem_has_stale();
        imem_rsp_valid = rsp_due();
        imem_rsp_data  = imem_rsp_valid ? mem_word(mem_q[0].addr) : $urandom;
        #1;
        check_output();
        @(posedge clock);
        update_models();
        cyc++;
    endtask

    initial begin
        logic        r_rst;
        logic        r_stl;
        logic        r_rdv;
        logic        r_rdy;
        logic [31:0] r_pc;
        $display("[TB] riscv_fetch_prefetch bench start");

        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] streaming with 1-cycle memory");
        lat = 1;
        repeat (12) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] stall held 6 cycles");
        repeat (6) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (8) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] redirect with slow memory");
        lat = 3;
        repeat (6) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
        repeat (10) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] redirect, response and stall together");
        for (int i = 0; i < 8 && !rsp_due(); i++) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        repeat (8) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] unaligned redirect and address wrap");
        lat = 1;
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b1);
        repeat (6) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (8) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] reset with fetches outstanding");
        lat = 3;
        repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (2) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        lat = 2;
        repeat (12) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] random phase");
        repeat (600) begin
            lat   = $urandom_range(1, 4);
            r_rst = ($urandom_range(0, 99) == 0);
            r_stl = ($urandom_range(0, 99) < 20);
            r_rdv = ($urandom_range(0, 99) < 5);
            r_rdy = ($urandom_range(0, 99) < 70);
            r_pc  = $urandom;
            apply_stimulus(r_rst, r_stl, r_rdv, r_pc, r_rdy);
        end

        lat = 1;
        repeat (12) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "[TB] time limit");
    end

endmodule
